// File: rtl/lsm_regress_accum.sv
// LSM regression feeder: accumulates sample moments for one exercise date,
// forms the slope numerator/denominator for the divider and captures beta.
module lsm_regress_accum #(
  parameter int WIDTH   = 32,
  parameter int QINT    = 16,
  parameter int QFRAC   = WIDTH - QINT,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = 16,
  parameter int DIV_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  output logic             div_issue,
  input  logic [WIDTH-1:0] div_result,
  output logic [WIDTH-1:0] beta,
  output logic             beta_valid,
  output logic             beta_err,
  output logic             beta_sat
);
  localparam int PW   = 2 * WIDTH;
  localparam int AW2  = 2 * ACC_W;
  localparam int WC_W = $clog2(DIV_LAT + 2);

  typedef enum logic [2:0] {ACCUM, CALC1, CALC2, ISSUE, WAIT, DONE_ERR} state_t;
  state_t state, state_nxt;

  logic signed [ACC_W-1:0] sum_x, sum_y, sum_xx, sum_xy;
  logic        [CNT_W-1:0] cnt;
  logic signed [CNT_W:0]   n_s;
  logic signed [PW-1:0]    sx, sy, x_xx, x_xy;
  logic signed [AW2-1:0]   p_nxy, p_nxx, p_xy, p_xx;
  logic signed [AW2-1:0]   num_full, den_full;
  logic        [WC_W-1:0]  wait_cnt;
  logic                    sat_pend;
  logic                    accept, wait_done, clear_acc;

  function automatic logic fits_w(input logic signed [AW2-1:0] v);
    return (&v[AW2-1:WIDTH-1]) || !(|v[AW2-1:WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_w(input logic signed [AW2-1:0] v);
    if (fits_w(v)) return v[WIDTH-1:0];
    return v[AW2-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign sx        = PW'($signed(in_x));
  assign sy        = PW'($signed(in_y));
  assign x_xx      = (sx * sx) >>> QFRAC;
  assign x_xy      = (sx * sy) >>> QFRAC;
  assign n_s       = {1'b0, cnt};
  assign num_full  = p_nxy - p_xy;
  assign den_full  = p_nxx - p_xx;
  assign accept    = in_valid && in_ready;
  // Counter is loaded with DIV_LAT in ISSUE; capture happens on the cycle
  // the decrement takes it to zero, giving DIV_LAT+1 cycles issue-to-valid.
  assign wait_done = (wait_cnt == WC_W'(1));
  assign clear_acc = ((state == WAIT) && wait_done) || (state == DONE_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:    if (accept && in_last) state_nxt = CALC1;
      CALC1:    state_nxt = CALC2;
      CALC2:    state_nxt = (den_full == '0) ? DONE_ERR : ISSUE;
      ISSUE:    state_nxt = WAIT;
      WAIT:     if (wait_done) state_nxt = ACCUM;
      DONE_ERR: state_nxt = ACCUM;
      default:  state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == ACCUM);
    div_issue = (state == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xx <= '0;
      sum_xy <= '0;
      cnt    <= '0;
    end else if (clear_acc) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xx <= '0;
      sum_xy <= '0;
      cnt    <= '0;
    end else if (accept) begin
      sum_x  <= sum_x  + ACC_W'($signed(in_x));
      sum_y  <= sum_y  + ACC_W'($signed(in_y));
      sum_xx <= sum_xx + ACC_W'(x_xx);
      sum_xy <= sum_xy + ACC_W'(x_xy);
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_nxy      <= '0;
      p_nxx      <= '0;
      p_xy       <= '0;
      p_xx       <= '0;
      sat_pend   <= 1'b0;
      wait_cnt   <= '0;
      div_num    <= '0;
      div_den    <= '0;
      beta       <= '0;
      beta_valid <= 1'b0;
      beta_err   <= 1'b0;
      beta_sat   <= 1'b0;
    end else begin
      beta_valid <= 1'b0;
      case (state)
        CALC1: begin
          p_nxy <= AW2'(n_s) * AW2'(sum_xy);
          p_nxx <= AW2'(n_s) * AW2'(sum_xx);
          p_xy  <= (AW2'(sum_x) * AW2'(sum_y)) >>> QFRAC;
          p_xx  <= (AW2'(sum_x) * AW2'(sum_x)) >>> QFRAC;
        end
        CALC2: begin
          sat_pend <= !fits_w(num_full) || !fits_w(den_full);
          // Operands only change when a division is actually going to be issued.
          if (den_full != '0) begin
            div_num <= clamp_w(num_full);
            div_den <= clamp_w(den_full);
          end
        end
        ISSUE: wait_cnt <= WC_W'(DIV_LAT);
        WAIT: begin
          wait_cnt <= wait_cnt - WC_W'(1);
          if (wait_done) begin
            beta       <= div_result;
            beta_valid <= 1'b1;
            beta_err   <= 1'b0;
            beta_sat   <= sat_pend;
          end
        end
        DONE_ERR: begin
          beta       <= '0;
          beta_valid <= 1'b1;
          beta_err   <= 1'b1;
          beta_sat   <= sat_pend;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsm_regress_accum.sv
// Bench for lsm_regress_accum: directed sample sets with hand-computed
// divider operands and beta, checked by a scoreboard monitor on negedge.
module tb_lsm_regress_accum;
  localparam int WIDTH   = 32;
  localparam int QFRAC   = 16;
  localparam int DIV_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_x, in_y;
  logic [WIDTH-1:0] div_num, div_den, div_result, beta;
  logic             div_issue, beta_valid, beta_err, beta_sat;

  always #5 clk = ~clk;

  lsm_regress_accum #(
    .WIDTH(WIDTH), .QINT(16), .ACC_W(48), .CNT_W(16), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_x(in_x), .in_y(in_y),
    .div_num(div_num), .div_den(div_den), .div_issue(div_issue),
    .div_result(div_result),
    .beta(beta), .beta_valid(beta_valid), .beta_err(beta_err), .beta_sat(beta_sat)
  );

  // Behavioural pipelined divider; output is garbage unless an issue is due.
  logic [WIDTH-1:0] dq [DIV_LAT];
  logic             dv [DIV_LAT];

  function automatic logic [WIDTH-1:0] qdiv(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    longint nn, dd;
    nn = longint'($signed(n)) <<< QFRAC;
    dd = longint'($signed(d));
    if (dd == 0) return '0;
    return WIDTH'(nn / dd);
  endfunction

  initial for (int i = 0; i < DIV_LAT; i++) begin dq[i] = '0; dv[i] = 1'b0; end

  always @(posedge clk) begin
    dq[0] <= qdiv(div_num, div_den);
    dv[0] <= div_issue;
    for (int i = 1; i < DIV_LAT; i++) begin
      dq[i] <= dq[i-1];
      dv[i] <= dv[i-1];
    end
  end
  assign div_result = dv[DIV_LAT-1] ? dq[DIV_LAT-1] : 32'hDEAD_BEEF;

  typedef struct { logic [31:0] num; logic [31:0] den; } iss_t;
  typedef struct { logic [31:0] beta; logic err; logic sat; logic via_div; } res_t;
  iss_t iss_q[$];
  res_t res_q[$];
  iss_t mon_iss;
  res_t mon_res;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q(input int v);
    return 32'(v) << QFRAC;
  endfunction

  task automatic push_iss(input logic [31:0] n, input logic [31:0] d);
    iss_t e;
    e.num = n; e.den = d;
    iss_q.push_back(e);
  endtask

  task automatic push_res(input logic [31:0] b, input logic e, input logic s, input logic v);
    res_t r;
    r.beta = b; r.err = e; r.sat = s; r.via_div = v;
    res_q.push_back(r);
  endtask

  // Monitor: decoupled from stimulus, pops expectations on DUT strobes.
  int   cyc = 0;
  int   issue_cyc = -100;
  logic issue_seen = 1'b0;
  logic prev_bv = 1'b0, prev_di = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (div_issue) begin
        check("div_issue pulse width", prev_di, 0);
        check("div_issue expected", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) begin
          mon_iss = iss_q.pop_front();
          check("div_num", div_num, mon_iss.num);
          check("div_den", div_den, mon_iss.den);
        end
        issue_seen = 1'b1;
        issue_cyc  = cyc;
      end
      if (beta_valid) begin
        check("beta_valid pulse width", prev_bv, 0);
        check("beta_valid expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          mon_res = res_q.pop_front();
          check("beta", beta, mon_res.beta);
          check("beta_err", beta_err, mon_res.err);
          check("beta_sat", beta_sat, mon_res.sat);
          if (mon_res.via_div) check("issue-to-beta latency", cyc - issue_cyc, DIV_LAT + 1);
          else                 check("div_issue on error path", issue_seen, 0);
        end
        issue_seen = 1'b0;
      end
      prev_bv = beta_valid;
      prev_di = div_issue;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic last);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (!in_ready) check("in_ready wait bound", in_ready, 1);
    in_valid = 1'b1; in_x = x; in_y = y; in_last = last;
  endtask

  // After the final sample, count blocked cycles; optionally keep in_valid high with noise.
  task automatic drain(input int exp_stall, input logic noisy);
    int stall = 0;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (in_ready) break;
      stall++;
      in_valid = noisy;
      in_x     = $urandom;
      in_y     = $urandom;
      in_last  = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("blocked cycles", stall, exp_stall);
  endtask

  initial begin
    in_valid = 1'b0; in_last = 1'b0; in_x = '0; in_y = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset beta", beta, 0);
    check("reset beta_valid", beta_valid, 0);
    check("reset beta_err", beta_err, 0);
    check("reset beta_sat", beta_sat, 0);
    check("reset div_issue", div_issue, 0);
    check("reset div_num", div_num, 0);
    check("reset div_den", div_den, 0);
    rst_n = 1'b1;
    #1 check("in_ready after reset", in_ready, 1);

    // Slope 2 through the divider
    push_iss(32'h000C_0000, 32'h0006_0000); push_res(32'h0002_0000, 0, 0, 1);
    send(q(1), q(2), 0); send(q(2), q(4), 0); send(q(3), q(6), 1);
    drain(3 + DIV_LAT, 0);

    // Identical x values: zero denominator
    push_res(32'h0, 1, 0, 0);
    send(q(1), q(0), 0); send(q(1), q(5), 1);
    drain(3, 0);

    // Both operands clamp to max positive
    push_iss(32'h7FFF_FFFF, 32'h7FFF_FFFF); push_res(32'h0001_0000, 0, 1, 1);
    send(q(100), q(200), 0); send(q(-100), q(-200), 1);
    drain(3 + DIV_LAT, 0);

    // in_valid held high with noise while busy, then a clean set
    push_iss(32'h000C_0000, 32'h0006_0000); push_res(32'h0002_0000, 0, 0, 1);
    send(q(1), q(2), 0); send(q(2), q(4), 0); send(q(3), q(6), 1);
    drain(3 + DIV_LAT, 1);
    push_iss(32'h0004_0000, 32'h0004_0000); push_res(32'h0001_0000, 0, 0, 1);
    send(q(2), q(2), 0); send(q(4), q(4), 1);
    drain(3 + DIV_LAT, 0);

    // Reset while waiting on the divider; its result must be dropped
    push_iss(32'h000C_0000, 32'h0006_0000);
    send(q(1), q(2), 0); send(q(2), q(4), 0); send(q(3), q(6), 1);
    begin
      int g = 0;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      while (!div_issue && g < 20) begin @(negedge clk); g++; end
      if (!div_issue) check("div_issue wait bound", div_issue, 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset in_ready", in_ready, 0);
    check("mid-reset beta", beta, 0);
    check("mid-reset beta_sat", beta_sat, 0);
    check("mid-reset div_num", div_num, 0);
    check("mid-reset div_den", div_den, 0);
    check("mid-reset div_issue", div_issue, 0);
    #1 rst_n = 1'b1;
    #1 check("in_ready after mid reset", in_ready, 1);
    repeat (DIV_LAT + 2) @(negedge clk);
    push_iss(32'h0002_0000, 32'h0001_0000); push_res(32'h0002_0000, 0, 0, 1);
    send(q(0), q(1), 0); send(q(1), q(3), 1);
    drain(3 + DIV_LAT, 0);

    // Single-sample set
    push_res(32'h0, 1, 0, 0);
    send(q(5), q(7), 1);
    drain(3, 0);

    repeat (5) @(negedge clk);
    check("pending div_issue expectations", iss_q.size(), 0);
    check("pending beta expectations", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end
endmodule
